// File: rtl/alu_exec_unit_if.sv
// Handshake and data bundle between the operand mux, alu_exec_unit and writeback.
// The master drives requests and takes results; the slave is the execution unit.
interface alu_exec_unit_if #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         alu_ctrl;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  result;
    logic               zero;
    logic               overflow;
    logic               illegal;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle EX-stage ALU with valid/ready on both sides.
// Define FAST_SHIFT_EN for a single-cycle barrel shifter; otherwise shifts take one cycle per bit.
module alu_exec_unit #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input logic          clk,
    input logic          rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_ADD = 4'd2,  OP_SLL = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4,  OP_SUB  = 4'd6,  OP_SLT = 4'd7,  OP_ADDU = 4'd8;
    localparam logic [3:0] OP_SUBU = 4'd9,  OP_XOR  = 4'd10, OP_SLTU = 4'd11, OP_NOR = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13, OP_LUI  = 4'd14;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DONE  = 2'd2;
`ifndef FAST_SHIFT_EN
    localparam logic [1:0] ST_SHIFT = 2'd1;
`endif

    localparam int M = DATA_W - 1;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              ovf;
        logic              ill;
    } alu_res_t;

    logic [1:0]        state;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              overflow_q;
    logic              illegal_q;
    alu_res_t          accept_res;

    function automatic logic is_shift(input logic [3:0] c);
        return (c == OP_SLL) || (c == OP_SRL) || (c == OP_SRA);
    endfunction

    // Shift codes return op_b unchanged here: that is the shamt=0 answer.
    function automatic alu_res_t compute(input logic [3:0] c,
                                         input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] sum;
        logic [DATA_W-1:0] diff;
        // NOTE: give every field a default before the case so no path leaves it unassigned (no latch).
        compute = '0;
        sum     = a + b;
        diff    = a - b;
        case (c)
            OP_AND:  compute.res = a & b;
            OP_OR:   compute.res = a | b;
            OP_ADD: begin
                compute.res = sum;
                compute.ovf = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                compute.res = diff;
                compute.ovf = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_SLT:  compute.res = {{(DATA_W-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: compute.res = {{(DATA_W-1){1'b0}}, a < b};
            OP_ADDU: compute.res = sum;
            OP_SUBU: compute.res = diff;
            OP_XOR:  compute.res = a ^ b;
            OP_NOR:  compute.res = ~(a | b);
            OP_LUI:  compute.res = {b[15:0], {(DATA_W-16){1'b0}}};
            OP_SLL, OP_SRL, OP_SRA: compute.res = b;
            default: compute.ill = 1'b1;
        endcase
    endfunction

    always_comb begin
        accept_res = compute(bus.alu_ctrl, bus.op_a, bus.op_b);
`ifdef FAST_SHIFT_EN
        case (bus.alu_ctrl)
            OP_SLL:  accept_res.res = bus.op_b << bus.shamt;
            OP_SRL:  accept_res.res = bus.op_b >> bus.shamt;
            OP_SRA:  accept_res.res = $signed(bus.op_b) >>> bus.shamt;
            default: ;
        endcase
`endif
    end

`ifndef FAST_SHIFT_EN
    logic [3:0]         ctrl_q;
    logic [DATA_W-1:0]  work;
    logic [DATA_W-1:0]  work_next;
    logic [SHAMT_W-1:0] cnt;

    always_comb begin
        case (ctrl_q)
            OP_SLL:  work_next = {work[M-1:0], 1'b0};
            OP_SRL:  work_next = {1'b0, work[M:1]};
            default: work_next = {work[M], work[M:1]};
        endcase
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
`ifndef FAST_SHIFT_EN
            ctrl_q     <= '0;
            work       <= '0;
            cnt        <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
`ifndef FAST_SHIFT_EN
                        if (is_shift(bus.alu_ctrl) && (bus.shamt != '0)) begin
                            ctrl_q <= bus.alu_ctrl;
                            work   <= bus.op_b;
                            cnt    <= bus.shamt;
                            state  <= ST_SHIFT;
                        end else
`endif
                        begin
                            result_q   <= accept_res.res;
                            zero_q     <= (accept_res.res == '0);
                            overflow_q <= accept_res.ovf;
                            illegal_q  <= accept_res.ill;
                            state      <= ST_DONE;
                        end
                    end
                end
`ifndef FAST_SHIFT_EN
                ST_SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        result_q   <= work_next;
                        zero_q     <= (work_next == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
`endif
                ST_DONE: if (bus.out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops against a reference model.
// Latency expectations follow FAST_SHIFT_EN when the bench is compiled with it.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus ();
    alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
    } exp_t;

    // Reference model: plain integer arithmetic on the architectural meaning of each code.
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] s);
        exp_t e;
        longint wide;
        logic signed [31:0] sb;
        e.res = 32'h0; e.ovf = 1'b0; e.ill = 1'b0;
        sb = b;
        case (c)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2: begin
                wide  = longint'($signed(a)) + longint'($signed(b));
                e.res = a + b;
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd3:  e.res = b << s;
            4'd4:  e.res = b >> s;
            4'd6: begin
                wide  = longint'($signed(a)) - longint'($signed(b));
                e.res = a - b;
                e.ovf = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd7:  e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:  e.res = a + b;
            4'd9:  e.res = a - b;
            4'd10: e.res = a ^ b;
            4'd11: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd12: e.res = ~(a | b);
            4'd13: e.res = sb >>> s;
            4'd14: e.res = {b[15:0], 16'h0};
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic int exp_lat(input logic [3:0] c, input logic [4:0] s);
`ifdef FAST_SHIFT_EN
        return 1;
`else
        return ((c == 4'd3 || c == 4'd4 || c == 4'd13) && s != 5'd0) ? 1 + int'(s) : 1;
`endif
    endfunction

    // Present an op for exactly one accept edge, then scramble the inputs.
    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] s);
        bus.alu_ctrl = c; bus.op_a = a; bus.op_b = b; bus.shamt = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 4'($urandom); bus.op_a = $urandom; bus.op_b = $urandom; bus.shamt = 5'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.zero, bus.overflow, bus.illegal} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_flags: got rdy/vld/z/o/i=%b want 10000",
                     {bus.in_ready, bus.out_valid, bus.zero, bus.overflow, bus.illegal});
        end
        n_cmp++;
        if (bus.result !== 32'h0) begin
            n_err++; $display("FAIL reset_result: got %h want 00000000", bus.result);
        end
    endtask

    // Runs one op and compares every observable field with the model.
    task automatic test_op(input string name, input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] s);
        exp_t e;
        int   lat;
        e = model(c, a, b, s);
        start_op(c, a, b, s);
        wait_done(lat);
        n_cmp++;
        if (lat !== exp_lat(c, s) || bus.out_valid !== 1'b1) begin
            n_err++; $display("FAIL %s_latency: got %0d (valid=%b) want %0d", name, lat, bus.out_valid, exp_lat(c, s));
        end
        n_cmp++;
        if (bus.result !== e.res) begin
            n_err++; $display("FAIL %s_result: got %h want %h (code %0d a=%h b=%h s=%0d)", name, bus.result, e.res, c, a, b, s);
        end
        n_cmp++;
        if ({bus.zero, bus.overflow, bus.illegal} !== {e.res == 32'h0, e.ovf, e.ill}) begin
            n_err++; $display("FAIL %s_flags: got z/o/i=%b want %b (code %0d)", name,
                              {bus.zero, bus.overflow, bus.illegal}, {e.res == 32'h0, e.ovf, e.ill}, c);
        end
        release_op();
    endtask

    task automatic test_arith();
        test_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'h1, 5'd0);
        test_op("addu",    4'd8, 32'h7FFF_FFFF, 32'h1, 5'd0);
        test_op("sub_eq",  4'd6, 32'd5, 32'd5, 5'd0);
        test_op("slt",     4'd7, 32'hFFFF_FFFF, 32'h1, 5'd0);
        test_op("sltu",    4'd11, 32'hFFFF_FFFF, 32'h1, 5'd0);
        test_op("sub_ovf", 4'd6, 32'h8000_0000, 32'h1, 5'd0);
    endtask

    task automatic test_shift();
        test_op("sra4",  4'd13, 32'h0, 32'h8000_0000, 5'd4);
        test_op("sra0",  4'd13, 32'h0, 32'h8000_0000, 5'd0);
        test_op("sll31", 4'd3,  32'h0, 32'h0000_0003, 5'd31);
        test_op("srl1",  4'd4,  32'h0, 32'h8000_0001, 5'd1);
    endtask

    task automatic test_illegal();
        test_op("ill15", 4'd15, 32'hFFFF, 32'hFFFF, 5'd0);
        test_op("and",   4'd0,  32'hF0F0, 32'hFF00, 5'd0);
        test_op("ill5",  4'd5,  32'h1234, 32'h5678, 5'd3);
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(4'd14, 32'h0, 32'h0000_1234, 5'd0);
        wait_done(lat);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.result !== 32'h1234_0000 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_err++; $display("FAIL hold_%0d: got res=%h vld=%b rdy=%b want 12340000 1 0",
                                  i, bus.result, bus.out_valid, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        release_op();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL after_release: got rdy=%b vld=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(4'd1, 32'h0F, 32'hF0, 5'd0);
        wait_done(lat);
        // Offer the next op in the same cycle the result is taken; it must not be accepted yet.
        bus.alu_ctrl = 4'd10; bus.op_a = 32'hAAAA_5555; bus.op_b = 32'hFFFF_0000; bus.shamt = 5'd0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_no_accept: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.result !== 32'h5555_5555) begin
            n_err++; $display("FAIL b2b_result: got vld=%b res=%h want 1 55555555", bus.out_valid, bus.result);
        end
        release_op();
    endtask

    task automatic test_reset_mid_shift();
        start_op(4'd3, 32'h0, 32'h0000_0001, 5'd20);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
            n_err++; $display("FAIL midshift_async: got vld=%b res=%h want 0 00000000", bus.out_valid, bus.result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'h0) begin
            n_err++; $display("FAIL midshift_release: got rdy=%b vld=%b res=%h want 1 0 00000000",
                              bus.in_ready, bus.out_valid, bus.result);
        end
        repeat (25) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++; $display("FAIL midshift_no_result: got vld=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            test_op("rand", 4'($urandom_range(0, 15)), a, b, 5'($urandom_range(0, 31)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.alu_ctrl = 4'd0; bus.op_a = 32'h0; bus.op_b = 32'h0; bus.shamt = 5'd0;
        test_reset();
        test_arith();
        test_shift();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
